// File: rtl/reverse_cipher_iter.sv
// reverse_cipher_iter
//   Iterative AES inverse cipher (InvCipher). One 128-bit block is decrypted
//   per pass by reusing a single reverse-round datapath for NR clock cycles.
//   Round keys are fetched from an external combinational store addressed by
//   key_idx_o.
//
// Parameters
//   NR   number of rounds (10, 12 or 14)
//   KIW  width of key_idx_o, 2**KIW must exceed NR
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   abort_i       (only with REVERSE_CIPHER_ABORT_EN) drop the block in flight
//   in_valid_i    ciphertext present on in_data_i
//   in_ready_o    core accepts a block (IDLE only)
//   in_data_i     ciphertext, byte 0 in [127:120], column-major state order
//   key_idx_o     index of the round key needed this cycle
//   round_key_i   round key selected by key_idx_o
//   out_valid_o   plaintext present on out_data_o
//   out_ready_i   sink accepts out_data_o
//   out_data_o    plaintext, same byte order as in_data_i
//   busy_o        block in ROUND or DONE
//
// Optional feature macro: REVERSE_CIPHER_ABORT_EN (adds abort_i).
module reverse_cipher_iter #(
   parameter int NR  = 10,
   parameter int KIW = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef REVERSE_CIPHER_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [127:0]     in_data_i,
   output logic [KIW-1:0]   key_idx_o,
   input  logic [127:0]     round_key_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [127:0]     out_data_o,
   output logic             busy_o
);

   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("reverse_cipher_iter: NR must be 10, 12 or 14");
   end
   if ((1 << KIW) <= NR) begin : g_bad_kiw
      $error("reverse_cipher_iter: KIW too narrow for NR");
   end

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [KIW-1:0] R_FIRST = KIW'(NR - 1);
   localparam logic [KIW-1:0] K_LAST  = KIW'(NR);
   localparam logic [KIW-1:0] R_ONE   = KIW'(1);
   localparam logic [KIW-1:0] R_ZERO  = KIW'(0);

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      inv_sbox = INV_SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant: bits of k select b, 2b, 4b, 8b.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      gf_mul = (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      inv_mix_col = {
         gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
         gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
         gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
         gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      end
      inv_mix = o;
   endfunction

   // InvShiftRows then InvSubBytes: row r is rotated right by r columns.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      int src;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = r + 4*((c - r + 4) % 4);
            o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*src -: 8]);
         end
      end
      inv_shift_sub = o;
   endfunction

   logic [1:0]     fsm_q, fsm_d;
   logic [127:0]   state_q, state_d;
   logic [KIW-1:0] r_q, r_d;
   logic [127:0]   ark;
   logic [127:0]   round_out;
   logic           abort_req;

`ifdef REVERSE_CIPHER_ABORT_EN
   assign abort_req = abort_i;
`else
   assign abort_req = 1'b0;
`endif

   // An asserted abort also blocks acceptance in IDLE.
   assign in_ready_o  = (fsm_q == S_IDLE) && !abort_req;
   assign out_valid_o = (fsm_q == S_DONE);
   assign busy_o      = (fsm_q != S_IDLE);
   assign out_data_o  = state_q;

   // Reverse round datapath; the final round (r == 0) skips InvMixColumns.
   always_comb begin
      ark = inv_shift_sub(state_q) ^ round_key_i;
      if (r_q != R_ZERO) begin
         round_out = inv_mix(ark);
      end else begin
         round_out = ark;
      end
   end

   // Round key index decoded from registered state only.
   always_comb begin
      case (fsm_q)
         S_IDLE:  key_idx_o = K_LAST;
         S_ROUND: key_idx_o = r_q;
         S_DONE:  key_idx_o = R_ZERO;
         default: key_idx_o = K_LAST;
      endcase
   end

   // Next-state logic for FSM, cipher state and round counter.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      r_d     = r_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid_i && in_ready_o) begin
               state_d = in_data_i ^ round_key_i;
               r_d     = R_FIRST;
               fsm_d   = S_ROUND;
            end else begin
               fsm_d = S_IDLE;
            end
         end
         S_ROUND: begin
            state_d = round_out;
            if (r_q == R_ZERO) begin
               fsm_d = S_DONE;
            end else begin
               r_d = r_q - R_ONE;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               fsm_d = S_IDLE;
            end else begin
               fsm_d = S_DONE;
            end
         end
         default: begin
            fsm_d   = S_IDLE;
            state_d = 128'h0;
            r_d     = R_ZERO;
         end
      endcase
      // Abort overrides everything, including a same-cycle output handshake.
      if (abort_req && (fsm_q != S_IDLE)) begin
         fsm_d   = S_IDLE;
         state_d = 128'h0;
         r_d     = R_ZERO;
      end else begin
         fsm_d = fsm_d;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q   <= S_IDLE;
         state_q <= 128'h0;
         r_q     <= R_ZERO;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         r_q     <= r_d;
      end
   end

endmodule

// File: tb/tb_reverse_cipher_iter.sv
// Directed testbench for reverse_cipher_iter: FIPS-197 vectors for AES-128
// and AES-256, latency and key index sequence, backpressure, back-to-back
// blocks, asynchronous reset mid-block and (with REVERSE_CIPHER_ABORT_EN)
// abort behaviour.
module tb_reverse_cipher_iter;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [127:0] keys [0:2][0:15];
   logic [1:0]   key_sel = 2'd0;

   logic         in_valid10 = 1'b0, out_ready10 = 1'b0;
   logic [127:0] in_data10 = 128'h0;
   logic         in_ready10, out_valid10, busy10;
   logic [3:0]   key_idx10;
   logic [127:0] round_key10, out_data10;

   logic         in_valid14 = 1'b0, out_ready14 = 1'b0;
   logic [127:0] in_data14 = 128'h0;
   logic         in_ready14, out_valid14, busy14;
   logic [3:0]   key_idx14;
   logic [127:0] round_key14, out_data14;

`ifdef REVERSE_CIPHER_ABORT_EN
   logic abort10 = 1'b0;
   logic abort14 = 1'b0;
`endif

   assign round_key10 = keys[key_sel][key_idx10];
   assign round_key14 = keys[2][key_idx14];

   int checks = 0;
   int errors = 0;

   reverse_cipher_iter #(.NR(10), .KIW(4)) dut10 (
      .clk_i(clk), .rst_i(rst),
`ifdef REVERSE_CIPHER_ABORT_EN
      .abort_i(abort10),
`endif
      .in_valid_i(in_valid10), .in_ready_o(in_ready10), .in_data_i(in_data10),
      .key_idx_o(key_idx10), .round_key_i(round_key10),
      .out_valid_o(out_valid10), .out_ready_i(out_ready10), .out_data_o(out_data10),
      .busy_o(busy10));

   reverse_cipher_iter #(.NR(14), .KIW(4)) dut14 (
      .clk_i(clk), .rst_i(rst),
`ifdef REVERSE_CIPHER_ABORT_EN
      .abort_i(abort14),
`endif
      .in_valid_i(in_valid14), .in_ready_o(in_ready14), .in_data_i(in_data14),
      .key_idx_o(key_idx14), .round_key_i(round_key14),
      .out_valid_o(out_valid14), .out_ready_i(out_ready14), .out_data_o(out_data14),
      .busy_o(busy14));

   function automatic logic [7:0] sb(input logic [7:0] b);
      sb = SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      subword = {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   // Standard AES key expansion into keys[set][0..nr].
   task automatic expand(input int set, input logic [255:0] key, input int nk, input int nr);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k <= nr; k++) keys[set][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready10 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready10); end
      checks++; if (out_valid10 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid10); end
      checks++; if (out_data10 !== 128'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data10); end
      checks++; if (key_idx10 !== 4'd10) begin errors++; $display("FAIL rst_key_idx10 got %0d want 10", key_idx10); end
      checks++; if (busy10 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy10); end
      checks++; if (key_idx14 !== 4'd14) begin errors++; $display("FAIL rst_key_idx14 got %0d want 14", key_idx14); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_aes128;
      checks++; if (in_ready10 !== 1'b1 || key_idx10 !== 4'd10) begin
         errors++; $display("FAIL a128_idle got rdy=%b idx=%0d want rdy=1 idx=10", in_ready10, key_idx10); end
      in_valid10 = 1'b1; in_data10 = CT_A;
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++; if (key_idx10 !== 4'(9 - k) || out_valid10 !== 1'b0 || busy10 !== 1'b1) begin
            errors++; $display("FAIL a128_round%0d got idx=%0d ov=%b busy=%b want idx=%0d ov=0 busy=1",
                               k, key_idx10, out_valid10, busy10, 9 - k); end
         @(posedge clk); #1;
      end
      checks++; if (out_valid10 !== 1'b1 || key_idx10 !== 4'd0 || in_ready10 !== 1'b0) begin
         errors++; $display("FAIL a128_done got ov=%b idx=%0d rdy=%b want ov=1 idx=0 rdy=0",
                            out_valid10, key_idx10, in_ready10); end
      checks++; if (out_data10 !== PT_A) begin errors++; $display("FAIL a128_data got %h want %h", out_data10, PT_A); end
      out_ready10 = 1'b1;
      @(posedge clk); #1;
      out_ready10 = 1'b0;
      checks++; if (out_valid10 !== 1'b0 || in_ready10 !== 1'b1 || busy10 !== 1'b0) begin
         errors++; $display("FAIL a128_release got ov=%b rdy=%b busy=%b want 0 1 0", out_valid10, in_ready10, busy10); end
   endtask

   task automatic test_aes256;
      in_valid14 = 1'b1; in_data14 = CT_C;
      @(posedge clk); #1;
      in_valid14 = 1'b0;
      for (int k = 0; k < 14; k++) begin
         checks++; if (key_idx14 !== 4'(13 - k) || out_valid14 !== 1'b0) begin
            errors++; $display("FAIL a256_round%0d got idx=%0d ov=%b want idx=%0d ov=0",
                               k, key_idx14, out_valid14, 13 - k); end
         @(posedge clk); #1;
      end
      checks++; if (out_valid14 !== 1'b1) begin errors++; $display("FAIL a256_valid got %b want 1", out_valid14); end
      checks++; if (out_data14 !== PT_C) begin errors++; $display("FAIL a256_data got %h want %h", out_data14, PT_C); end
      out_ready14 = 1'b1;
      @(posedge clk); #1;
      out_ready14 = 1'b0;
      checks++; if (in_ready14 !== 1'b1 || busy14 !== 1'b0) begin
         errors++; $display("FAIL a256_release got rdy=%b busy=%b want 1 0", in_ready14, busy14); end
   endtask

   task automatic test_backpressure;
      in_valid10 = 1'b1; in_data10 = CT_A;
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      in_valid10 = 1'b1; in_data10 = CT_B;
      for (int k = 0; k < 5; k++) begin
         checks++; if (out_valid10 !== 1'b1 || in_ready10 !== 1'b0 || out_data10 !== PT_A) begin
            errors++; $display("FAIL bp_hold%0d got ov=%b rdy=%b data=%h want ov=1 rdy=0 data=%h",
                               k, out_valid10, in_ready10, out_data10, PT_A); end
         @(posedge clk); #1;
      end
      in_valid10 = 1'b0;
      out_ready10 = 1'b1;
      @(posedge clk); #1;
      out_ready10 = 1'b0;
      checks++; if (in_ready10 !== 1'b1 || out_valid10 !== 1'b0 || busy10 !== 1'b0 || key_idx10 !== 4'd10) begin
         errors++; $display("FAIL bp_release got rdy=%b ov=%b busy=%b idx=%0d want 1 0 0 10",
                            in_ready10, out_valid10, busy10, key_idx10); end
   endtask

   task automatic test_back_to_back;
      int cyc, n_acc, n_out;
      int acc_cyc [0:1];
      logic acc, hs;
      cyc = 0; n_acc = 0; n_out = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      key_sel = 2'd0;
      in_valid10 = 1'b1; in_data10 = CT_A; out_ready10 = 1'b1;
      while (n_out < 2 && cyc < 60) begin
         acc = in_valid10 && in_ready10;
         hs  = out_valid10 && out_ready10;
         if (hs) begin
            checks++; if (out_data10 !== (n_out == 0 ? PT_A : PT_B)) begin
               errors++; $display("FAIL b2b_data%0d got %h want %h", n_out, out_data10, (n_out == 0 ? PT_A : PT_B)); end
            n_out++;
         end
         if (acc && n_acc < 2) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         @(posedge clk); #1;
         if (acc && n_acc == 1) in_data10 = CT_B;
         if (acc && n_acc == 2) in_valid10 = 1'b0;
         if (hs && n_out == 1) key_sel = 2'd1;
         cyc++;
      end
      in_valid10 = 1'b0; out_ready10 = 1'b0;
      checks++; if (n_out != 2 || n_acc != 2) begin
         errors++; $display("FAIL b2b_count got acc=%0d out=%0d want 2 2", n_acc, n_out); end
      checks++; if (acc_cyc[1] - acc_cyc[0] != 12) begin
         errors++; $display("FAIL b2b_spacing got %0d want 12", acc_cyc[1] - acc_cyc[0]); end
      key_sel = 2'd0;
   endtask

   task automatic test_reset_mid;
      in_valid10 = 1'b1; in_data10 = CT_B;
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      checks++; if (busy10 !== 1'b1 || key_idx10 !== 4'd4) begin
         errors++; $display("FAIL rmid_pre got busy=%b idx=%0d want 1 4", busy10, key_idx10); end
      rst = 1'b1;
      #1;
      checks++; if (in_ready10 !== 1'b1 || out_valid10 !== 1'b0 || busy10 !== 1'b0 ||
                    key_idx10 !== 4'd10 || out_data10 !== 128'h0) begin
         errors++; $display("FAIL rmid_reset got rdy=%b ov=%b busy=%b idx=%0d data=%h want 1 0 0 10 0",
                            in_ready10, out_valid10, busy10, key_idx10, out_data10); end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      test_aes128();
   endtask

`ifdef REVERSE_CIPHER_ABORT_EN
   task automatic test_abort;
      int seen_valid;
      in_valid10 = 1'b1; in_data10 = CT_A;
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++; if (key_idx10 !== 4'd3) begin errors++; $display("FAIL ab_at_r3 got idx=%0d want 3", key_idx10); end
      abort10 = 1'b1;
      @(posedge clk); #1;
      abort10 = 1'b0;
      checks++; if (busy10 !== 1'b0 || out_valid10 !== 1'b0 || out_data10 !== 128'h0 || in_ready10 !== 1'b1) begin
         errors++; $display("FAIL ab_idle got busy=%b ov=%b data=%h rdy=%b want 0 0 0 1",
                            busy10, out_valid10, out_data10, in_ready10); end
      seen_valid = 0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid10 === 1'b1) seen_valid++;
         @(posedge clk); #1;
      end
      checks++; if (seen_valid != 0) begin errors++; $display("FAIL ab_no_output got %0d valid cycles want 0", seen_valid); end
      abort10 = 1'b1; in_valid10 = 1'b1; in_data10 = CT_A;
      #1;
      checks++; if (in_ready10 !== 1'b0) begin errors++; $display("FAIL ab_ready_low got %b want 0", in_ready10); end
      @(posedge clk); #1;
      abort10 = 1'b0; in_valid10 = 1'b0;
      checks++; if (busy10 !== 1'b0 || key_idx10 !== 4'd10) begin
         errors++; $display("FAIL ab_not_accepted got busy=%b idx=%0d want 0 10", busy10, key_idx10); end
   endtask
`endif

   initial begin
      for (int s = 0; s < 3; s++) for (int k = 0; k < 16; k++) keys[s][k] = 128'h0;
      expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
      expand(1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
      expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
      test_reset();
      test_aes128();
      test_aes256();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef REVERSE_CIPHER_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
